// File: rtl/int_trap_seq.sv
// Interrupt entry / mret sequencer: drains the pipeline, writes the trap or
// return CSR image for one cycle, then redirects fetch for one cycle.
module int_trap_seq #(
  parameter int unsigned MIN_DRAIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_en,
  input  logic [3:0]  int_code,
  input  logic        mret_req,
  input  logic [63:0] pc_commit,
  input  logic        pipe_idle,
  input  logic [63:0] mstatus_in,
  input  logic [63:0] mepc_in,
  input  logic [63:0] mtvec_in,
  output logic        stall_fetch,
  output logic        flush,
  output logic        csr_we,
  output logic [63:0] mepc_out,
  output logic [63:0] mcause_out,
  output logic [63:0] mstatus_out,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  priv_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP_WR,
    S_RET_WR,
    S_REDIR
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(MIN_DRAIN - 1);
  localparam logic [1:0] PRIV_M     = 2'd3;
  localparam logic [1:0] PRIV_U     = 2'd0;

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt;
  logic [63:0] lat_pc;
  logic [3:0]  lat_code;
  logic [1:0]  lat_priv;
  logic [63:0] redir_pc;
  logic [1:0]  priv;
  logic [63:0] tvec_base;
  logic [63:0] trap_target;

  assign tvec_base   = {mtvec_in[63:2], 2'b00};
  assign trap_target = (mtvec_in[1:0] == 2'b01) ? tvec_base + {58'd0, lat_code, 2'b00}
                                                : tvec_base;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt <= '0;
      lat_pc    <= '0;
      lat_code  <= '0;
      lat_priv  <= '0;
      redir_pc  <= '0;
      priv      <= PRIV_M;
    end else begin
      case (state)
        S_IDLE: begin
          if (!mret_req && int_en) begin
            lat_pc    <= pc_commit;
            lat_code  <= int_code;
            lat_priv  <= priv;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt != 4'hF) drain_cnt <= drain_cnt + 4'd1;
        end
        S_TRAP_WR: begin
          redir_pc <= trap_target;
          priv     <= PRIV_M;
        end
        S_RET_WR: begin
          // The mret target is captured here so REDIR is immune to mepc changes.
          redir_pc <= {mepc_in[63:2], 2'b00};
          priv     <= (mstatus_in[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    flush          = 1'b0;
    csr_we         = 1'b0;
    mepc_out       = '0;
    mcause_out     = '0;
    mstatus_out    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: begin
        if (mret_req)    state_nxt = S_RET_WR;
        else if (int_en) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The counter reads zero only in the cycle right after entry.
        flush = (drain_cnt == 4'd0);
        if (drain_cnt >= DRAIN_LAST && pipe_idle) state_nxt = S_TRAP_WR;
      end
      S_TRAP_WR: begin
        csr_we              = 1'b1;
        mepc_out            = {lat_pc[63:2], 2'b00};
        mcause_out          = {1'b1, 59'd0, lat_code};
        mstatus_out         = mstatus_in;
        mstatus_out[7]      = mstatus_in[3];
        mstatus_out[3]      = 1'b0;
        mstatus_out[12:11]  = lat_priv;
        state_nxt           = S_REDIR;
      end
      S_RET_WR: begin
        csr_we              = 1'b1;
        mepc_out            = mepc_in;
        mstatus_out         = mstatus_in;
        mstatus_out[3]      = mstatus_in[7];
        mstatus_out[7]      = 1'b1;
        mstatus_out[12:11]  = 2'b00;
        state_nxt           = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_pc;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign stall_fetch = busy;
  assign priv_out    = priv;

endmodule

// File: tb/tb_int_trap_seq.sv
// Directed bench for int_trap_seq: trap entry, drain wait, mret, priority,
// reset aborts and mtvec vectoring/wrap, all with hand-computed expectations.
module tb_int_trap_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_en;
  logic [3:0]  int_code;
  logic        mret_req;
  logic [63:0] pc_commit;
  logic        pipe_idle;
  logic [63:0] mstatus_in, mepc_in, mtvec_in;
  logic        stall_fetch, flush, csr_we, redirect_valid, busy;
  logic [63:0] mepc_out, mcause_out, mstatus_out, redirect_pc;
  logic [1:0]  priv_out;

  int n_checks = 0;
  int n_errors = 0;
  logic overlap_seen = 1'b0;
  logic abort_seen;

  int_trap_seq #(.MIN_DRAIN(2)) dut (
    .clk(clk), .reset(reset), .int_en(int_en), .int_code(int_code),
    .mret_req(mret_req), .pc_commit(pc_commit), .pipe_idle(pipe_idle),
    .mstatus_in(mstatus_in), .mepc_in(mepc_in), .mtvec_in(mtvec_in),
    .stall_fetch(stall_fetch), .flush(flush), .csr_we(csr_we),
    .mepc_out(mepc_out), .mcause_out(mcause_out), .mstatus_out(mstatus_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .priv_out(priv_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (csr_we && redirect_valid) overlap_seen = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; int_en = 1'b0; int_code = '0; mret_req = 1'b0;
    pc_commit = '0; pipe_idle = 1'b0; mstatus_in = '0; mepc_in = '0; mtvec_in = '0;
    tick(); tick();
    check("rst_busy",    busy, 0);
    check("rst_stall",   stall_fetch, 0);
    check("rst_flush",   flush, 0);
    check("rst_we",      csr_we, 0);
    check("rst_rv",      redirect_valid, 0);
    check("rst_priv",    priv_out, 3);
    check("rst_mepc",    mepc_out, 0);
    check("rst_mcause",  mcause_out, 0);
    check("rst_mstatus", mstatus_out, 0);
    check("rst_rpc",     redirect_pc, 0);
    reset = 1'b0;

    // Vectored trap from M-mode, MIE=1, code 7.
    mstatus_in = 64'h8; pc_commit = 64'h8000_0104; int_code = 4'd7;
    mtvec_in = 64'h8000_0001; pipe_idle = 1'b1; int_en = 1'b1;
    tick();
    check("t1_flush1", flush, 1);
    check("t1_stall",  stall_fetch, 1);
    check("t1_we_d1",  csr_we, 0);
    int_en = 1'b0;
    tick();
    check("t1_flush2", flush, 0);
    check("t1_we_d2",  csr_we, 0);
    tick();
    check("t1_we",      csr_we, 1);
    check("t1_mepc",    mepc_out, 64'h8000_0104);
    check("t1_mcause",  mcause_out, 64'h8000_0000_0000_0007);
    check("t1_mstatus", mstatus_out, 64'h1880);
    check("t1_rv_wr",   redirect_valid, 0);
    tick();
    check("t1_rv",   redirect_valid, 1);
    check("t1_rpc",  redirect_pc, 64'h8000_001C);
    check("t1_we_r", csr_we, 0);
    check("t1_priv", priv_out, 3);
    tick();
    check("t1_idle", busy, 0);
    check("t1_rv_i", redirect_valid, 0);

    // mret to U-mode: MPIE=1, MPP=0.
    mstatus_in = 64'h80; mepc_in = 64'h8000_0200; mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    check("t2_we",      csr_we, 1);
    check("t2_mepc",    mepc_out, 64'h8000_0200);
    check("t2_mcause",  mcause_out, 0);
    check("t2_mstatus", mstatus_out, 64'h88);
    check("t2_flush",   flush, 0);
    tick();
    check("t2_rv",   redirect_valid, 1);
    check("t2_rpc",  redirect_pc, 64'h8000_0200);
    check("t2_priv", priv_out, 0);
    check("t2_we_r", csr_we, 0);
    tick();
    check("t2_idle",  busy, 0);
    check("t2_priv2", priv_out, 0);

    // Drain wait from U-mode, direct mtvec with low bits set, misaligned PC.
    mstatus_in = 64'h1808; pc_commit = 64'h1003; int_code = 4'd11;
    mtvec_in = 64'hFFFF_FFFF_FFFF_FFFE; pipe_idle = 1'b0; int_en = 1'b1;
    tick();
    int_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t3_flush_c%0d", i), flush, (i == 1) ? 64'd1 : 64'd0);
      check($sformatf("t3_we_c%0d", i), csr_we, 0);
      check($sformatf("t3_stall_c%0d", i), stall_fetch, 1);
      if (i == 5) pipe_idle = 1'b1;
      tick();
    end
    check("t3_we",      csr_we, 1);
    check("t3_mepc",    mepc_out, 64'h1000);
    check("t3_mcause",  mcause_out, 64'h8000_0000_0000_000B);
    check("t3_mstatus", mstatus_out, 64'h80);
    check("t3_priv_wr", priv_out, 0);
    tick();
    check("t3_rv",   redirect_valid, 1);
    check("t3_rpc",  redirect_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t3_priv", priv_out, 3);
    tick();
    check("t3_idle", busy, 0);

    // Vectored mtvec that wraps past 2^64.
    mstatus_in = 64'h0; pc_commit = 64'h2000; int_code = 4'd11;
    mtvec_in = 64'hFFFF_FFFF_FFFF_FFFD; int_en = 1'b1;
    tick();
    int_en = 1'b0;
    tick(); tick();
    check("t4_we",      csr_we, 1);
    check("t4_mstatus", mstatus_out, 64'h1800);
    tick();
    check("t4_rpc", redirect_pc, 64'h28);
    tick();

    // mret and int_en together: mret wins, int_en is picked up afterwards.
    mstatus_in = 64'h80; mepc_in = 64'h8000_0306; int_code = 4'd3;
    pc_commit = 64'h3000; mret_req = 1'b1; int_en = 1'b1;
    tick();
    mret_req = 1'b0;
    check("t5_we",      csr_we, 1);
    check("t5_flush",   flush, 0);
    check("t5_mstatus", mstatus_out, 64'h88);
    tick();
    check("t5_rv",    redirect_valid, 1);
    check("t5_rpc",   redirect_pc, 64'h8000_0304);
    check("t5_priv",  priv_out, 0);
    tick();
    check("t5_idle",  busy, 0);
    tick();
    check("t5_drain", flush, 1);

    // Reset mid-DRAIN while in U-mode, int_en held through reset.
    reset = 1'b1;
    tick();
    check("t6_busy",  busy, 0);
    check("t6_priv",  priv_out, 3);
    check("t6_flush", flush, 0);
    check("t6_stall", stall_fetch, 0);
    reset = 1'b0;
    tick();
    check("t6_accept", flush, 1);
    int_en = 1'b0;
    tick(); tick();
    check("t6_we_trap", csr_we, 1);

    // Reset in TRAP_WR must suppress the redirect.
    reset = 1'b1;
    tick();
    check("t7_we",   csr_we, 0);
    check("t7_rv",   redirect_valid, 0);
    check("t7_busy", busy, 0);
    reset = 1'b0;
    abort_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      abort_seen = abort_seen | csr_we | redirect_valid;
      tick();
    end
    check("t7_quiet",   abort_seen, 0);
    check("no_overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
